// File: rtl/count_checker.sv
// count_checker: watches a modulo-(COUNT_SIZE+1) up/down counter that shares
// this clock. It predicts each next value from the previous sample, locks
// once the prediction holds, then flags mismatches and counts wraps.
module count_checker #(
  parameter int COUNT_SIZE = 10,
  parameter int ACQ_LEN    = 2,
  parameter int ERR_LIMIT  = 4
) (
  input  logic        clk,
  input  logic        clear,
  input  logic        chk_en,
  input  logic        cnt_clear_n,
  input  logic        up_down,
  input  logic [7:0]  qd,
  output logic        locked,
  output logic        err,
  output logic        err_sticky,
  output logic [7:0]  err_cnt,
  output logic [15:0] wrap_up_cnt,
  output logic [15:0] wrap_dn_cnt,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACQUIRE = 2'd1,
    S_TRACK   = 2'd2,
    S_FAULT   = 2'd3
  } state_t;

  localparam logic [7:0] TERM = 8'(COUNT_SIZE);

  state_t      r_state;
  logic        r_locked;
  logic        r_err;
  logic        r_err_sticky;
  logic [7:0]  r_err_cnt;
  logic [15:0] r_wrap_up_cnt;
  logic [15:0] r_wrap_dn_cnt;
  logic [7:0]  r_match;
  logic        r_have_prev;
  logic [7:0]  r_prev_qd;
  logic        r_prev_up;
  logic        r_prev_clr_n;

  logic [7:0]  w_expected;
  logic        w_mismatch;
  logic        w_wrap_up;
  logic        w_wrap_dn;
  logic [7:0]  w_match_nxt;
  logic [7:0]  w_err_cnt_nxt;

  // Saturating increments: counters stick at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Predict this cycle's qd from last cycle's sample and classify it.
  always_comb begin
    w_expected = 8'd0;
    if (r_prev_clr_n) begin
      if (r_prev_up) w_expected = (r_prev_qd == TERM) ? 8'd0 : r_prev_qd + 8'd1;
      else           w_expected = (r_prev_qd == 8'd0) ? TERM : r_prev_qd - 8'd1;
    end
    w_mismatch    = (qd != w_expected) || (qd > TERM);
    // A clear-driven return to zero is not a wrap, hence the prev_clr_n term.
    w_wrap_up     = r_prev_clr_n &  r_prev_up & (r_prev_qd == TERM) & (qd == 8'd0);
    w_wrap_dn     = r_prev_clr_n & ~r_prev_up & (r_prev_qd == 8'd0) & (qd == TERM);
    w_match_nxt   = r_match + 8'd1;
    w_err_cnt_nxt = sat_inc8(r_err_cnt);
  end

  // Checker FSM with registered outputs; clear overrides everything, then chk_en.
  always_ff @(posedge clk) begin
    if (clear) begin
      r_state       <= S_IDLE;
      r_locked      <= 1'b0;
      r_err         <= 1'b0;
      r_err_sticky  <= 1'b0;
      r_err_cnt     <= 8'd0;
      r_wrap_up_cnt <= 16'd0;
      r_wrap_dn_cnt <= 16'd0;
      r_match       <= 8'd0;
      r_have_prev   <= 1'b0;
      r_prev_qd     <= 8'd0;
      r_prev_up     <= 1'b0;
      r_prev_clr_n  <= 1'b0;
    end else begin
      r_prev_qd    <= qd;
      r_prev_up    <= up_down;
      r_prev_clr_n <= cnt_clear_n;
      r_err        <= 1'b0;
      if (!chk_en) begin
        r_state     <= S_IDLE;
        r_locked    <= 1'b0;
        r_match     <= 8'd0;
        r_have_prev <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state     <= S_ACQUIRE;
            r_match     <= 8'd0;
            r_have_prev <= 1'b0;
          end
          S_ACQUIRE: begin
            // The first cycle after entry only establishes a trusted sample.
            if (!r_have_prev) begin
              r_have_prev <= 1'b1;
            end else if (w_mismatch) begin
              r_match <= 8'd0;
            end else if (w_match_nxt == 8'(ACQ_LEN)) begin
              r_state  <= S_TRACK;
              r_locked <= 1'b1;
              r_match  <= 8'd0;
            end else begin
              r_match <= w_match_nxt;
            end
          end
          S_TRACK: begin
            if (w_mismatch) begin
              r_err        <= 1'b1;
              r_err_sticky <= 1'b1;
              r_err_cnt    <= w_err_cnt_nxt;
              r_locked     <= 1'b0;
              r_match      <= 8'd0;
              r_have_prev  <= 1'b0;
              r_state      <= (int'(w_err_cnt_nxt) >= ERR_LIMIT) ? S_FAULT : S_ACQUIRE;
            end else begin
              if (w_wrap_up) r_wrap_up_cnt <= sat_inc16(r_wrap_up_cnt);
              if (w_wrap_dn) r_wrap_dn_cnt <= sat_inc16(r_wrap_dn_cnt);
            end
          end
          S_FAULT: begin
            r_state <= S_FAULT;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign locked      = r_locked;
  assign err         = r_err;
  assign err_sticky  = r_err_sticky;
  assign err_cnt     = r_err_cnt;
  assign wrap_up_cnt = r_wrap_up_cnt;
  assign wrap_dn_cnt = r_wrap_dn_cnt;
  assign state       = r_state;

endmodule

// File: tb/tb_count_checker.sv
// Directed bench for count_checker (defaults COUNT_SIZE=10, ACQ_LEN=2,
// ERR_LIMIT=4). Each record holds the inputs applied before one rising edge
// and the outputs required just after it.
module tb_count_checker;

  logic        clk = 1'b0;
  logic        clear, chk_en, cnt_clear_n, up_down;
  logic [7:0]  qd;
  logic        locked, err, err_sticky;
  logic [7:0]  err_cnt;
  logic [15:0] wrap_up_cnt, wrap_dn_cnt;
  logic [1:0]  state;

  int n_cmp = 0;
  int n_bad = 0;

  count_checker #(.COUNT_SIZE(10), .ACQ_LEN(2), .ERR_LIMIT(4)) dut (
    .clk(clk), .clear(clear), .chk_en(chk_en), .cnt_clear_n(cnt_clear_n),
    .up_down(up_down), .qd(qd), .locked(locked), .err(err),
    .err_sticky(err_sticky), .err_cnt(err_cnt), .wrap_up_cnt(wrap_up_cnt),
    .wrap_dn_cnt(wrap_dn_cnt), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        clr, en, cn, up;
    logic [7:0]  q;
    logic        l, e, s;
    logic [7:0]  ec;
    logic [15:0] wu, wd;
    logic [1:0]  st;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic clr, en, cn, up, input logic [7:0] q,
                              input logic l, e, s, input logic [7:0] ec,
                              input logic [15:0] wu, wd, input logic [1:0] st);
    vec_t v;
    v.clr = clr; v.en = en; v.cn = cn; v.up = up; v.q = q;
    v.l = l; v.e = e; v.s = s; v.ec = ec; v.wu = wu; v.wd = wd; v.st = st;
    return v;
  endfunction

  task automatic run(input string name, input vec_t v);
    clear = v.clr; chk_en = v.en; cnt_clear_n = v.cn; up_down = v.up; qd = v.q;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({locked, err, err_sticky, err_cnt, wrap_up_cnt, wrap_dn_cnt, state} !==
        {v.l, v.e, v.s, v.ec, v.wu, v.wd, v.st}) begin
      n_bad++;
      $display("FAIL %s qd=%0d: got locked=%b err=%b sticky=%b err_cnt=%0d wup=%0d wdn=%0d state=%0d, want locked=%b err=%b sticky=%b err_cnt=%0d wup=%0d wdn=%0d state=%0d",
               name, v.q, locked, err, err_sticky, err_cnt, wrap_up_cnt, wrap_dn_cnt, state,
               v.l, v.e, v.s, v.ec, v.wu, v.wd, v.st);
    end
  endtask

  initial begin
    clear = 1'b1; chk_en = 1'b0; cnt_clear_n = 1'b1; up_down = 1'b1; qd = 8'd0;

    // Reset, acquire from 0 counting up, lock after three samples.
    tbl.push_back(mk(1,0,1,1, 0,  0,0,0,0, 0,0, 0));
    tbl.push_back(mk(0,1,1,1, 0,  0,0,0,0, 0,0, 1));
    tbl.push_back(mk(0,1,1,1, 1,  0,0,0,0, 0,0, 1));
    tbl.push_back(mk(0,1,1,1, 2,  0,0,0,0, 0,0, 1));
    tbl.push_back(mk(0,1,1,1, 3,  1,0,0,0, 0,0, 2));
    for (int q = 4; q <= 10; q++) tbl.push_back(mk(0,1,1,1, 8'(q), 1,0,0,0, 0,0, 2));
    tbl.push_back(mk(0,1,1,1, 0,  1,0,0,0, 1,0, 2));
    for (int q = 1; q <= 10; q++) tbl.push_back(mk(0,1,1,1, 8'(q), 1,0,0,0, 1,0, 2));
    tbl.push_back(mk(0,1,1,1, 0,  1,0,0,0, 2,0, 2));
    // Turn around and wrap down 0 -> 10.
    tbl.push_back(mk(0,1,1,0, 1,  1,0,0,0, 2,0, 2));
    tbl.push_back(mk(0,1,1,0, 0,  1,0,0,0, 2,0, 2));
    tbl.push_back(mk(0,1,1,0, 10, 1,0,0,0, 2,1, 2));
    tbl.push_back(mk(0,1,1,0, 9,  1,0,0,0, 2,1, 2));
    // Up again; counter clear at 10 forces 0 without a wrap count.
    tbl.push_back(mk(0,1,1,1, 8,  1,0,0,0, 2,1, 2));
    tbl.push_back(mk(0,1,1,1, 9,  1,0,0,0, 2,1, 2));
    tbl.push_back(mk(0,1,0,1, 10, 1,0,0,0, 2,1, 2));
    tbl.push_back(mk(0,1,1,1, 0,  1,0,0,0, 2,1, 2));
    tbl.push_back(mk(0,1,1,1, 1,  1,0,0,0, 2,1, 2));

    foreach (tbl[i]) run($sformatf("tbl%0d", i), tbl[i]);

    // Single injected error: 5 where 7 is due, then relock.
    for (int q = 2; q <= 6; q++) run("track", mk(0,1,1,1, 8'(q), 1,0,0,0, 2,1, 2));
    run("err1",      mk(0,1,1,1, 5,  0,1,1,1, 2,1, 1));
    run("err1_pulse",mk(0,1,1,1, 8,  0,0,1,1, 2,1, 1));
    run("reacq1",    mk(0,1,1,1, 9,  0,0,1,1, 2,1, 1));
    run("relock1",   mk(0,1,1,1, 10, 1,0,1,1, 2,1, 2));

    // Second error; acquire-phase mismatch zeroes the match count silently,
    // and a wrap seen while acquiring is not counted.
    run("err2",      mk(0,1,1,1, 7,  0,1,1,2, 2,1, 1));
    run("cap2",      mk(0,1,1,1, 2,  0,0,1,2, 2,1, 1));
    run("acq_m1",    mk(0,1,1,1, 3,  0,0,1,2, 2,1, 1));
    run("acq_bad",   mk(0,1,1,1, 9,  0,0,1,2, 2,1, 1));
    run("acq_re1",   mk(0,1,1,1, 10, 0,0,1,2, 2,1, 1));
    run("relock2",   mk(0,1,1,1, 0,  1,0,1,2, 2,1, 2));

    // Third and fourth errors: the fourth enters FAULT.
    run("err3",      mk(0,1,1,1, 7,  0,1,1,3, 2,1, 1));
    run("cap3",      mk(0,1,1,1, 2,  0,0,1,3, 2,1, 1));
    run("acq3",      mk(0,1,1,1, 3,  0,0,1,3, 2,1, 1));
    run("relock3",   mk(0,1,1,1, 4,  1,0,1,3, 2,1, 2));
    run("err4_fault",mk(0,1,1,1, 7,  0,1,1,4, 2,1, 3));
    run("fault_hold",mk(0,1,1,1, 7,  0,0,1,4, 2,1, 3));
    run("fault_hold2",mk(0,1,1,1,3,  0,0,1,4, 2,1, 3));
    run("dis_idle",  mk(0,0,1,1, 9,  0,0,1,4, 2,1, 0));

    // Re-enable, lock, fault again, then clear with chk_en still high.
    run("reen",      mk(0,1,1,1, 0,  0,0,1,4, 2,1, 1));
    run("reen_cap",  mk(0,1,1,1, 1,  0,0,1,4, 2,1, 1));
    run("reen_m1",   mk(0,1,1,1, 2,  0,0,1,4, 2,1, 1));
    run("reen_lock", mk(0,1,1,1, 3,  1,0,1,4, 2,1, 2));
    run("err5_fault",mk(0,1,1,1, 9,  0,1,1,5, 2,1, 3));
    run("clr_fault", mk(1,1,1,1, 10, 0,0,0,0, 0,0, 0));
    run("post_clr",  mk(0,1,1,1, 0,  0,0,0,0, 0,0, 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
